// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_pkg : default 640x480 timing, derived totals, pixel and FSM types.
// Rev 1.0 : initial release (VGA_COLORBAR_EN selects the fill pattern).
// ============================================================================
package vga_pkg;

  localparam int C_H_ACTIVE = 640;
  localparam int C_H_FP     = 16;
  localparam int C_H_SYNC   = 96;
  localparam int C_H_BP     = 48;
  localparam int C_V_ACTIVE = 480;
  localparam int C_V_FP     = 10;
  localparam int C_V_SYNC   = 2;
  localparam int C_V_BP     = 33;

  localparam int C_H_TOTAL  = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;
  localparam int C_V_TOTAL  = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;
  localparam int C_HS_START = C_H_ACTIVE + C_H_FP;
  localparam int C_HS_END   = C_HS_START + C_H_SYNC;
  localparam int C_VS_START = C_V_ACTIVE + C_V_FP;
  localparam int C_VS_END   = C_VS_START + C_V_SYNC;

  // Counter width; bit 8 must exist for the colour-bar index h[8:6].
  localparam int C_CW = 10;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DROP = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vga_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_scan : h/v scan counters with visible, sync, first-pixel and fill decode.
// Rev 1.0  : fill shows colour bars when VGA_COLORBAR_EN is defined.
// ============================================================================
module vga_scan
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = C_H_ACTIVE,
  parameter int H_FP     = C_H_FP,
  parameter int H_SYNC   = C_H_SYNC,
  parameter int H_BP     = C_H_BP,
  parameter int V_ACTIVE = C_V_ACTIVE,
  parameter int V_FP     = C_V_FP,
  parameter int V_SYNC   = C_V_SYNC,
  parameter int V_BP     = C_V_BP
) (
  input  logic    pclk,
  input  logic    reset_n,
  output logic    o_visible,
  output logic    o_first,
  output logic    o_hsync_n,
  output logic    o_vsync_n,
  output logic    o_hact,
  output logic    o_vact,
  output rgb565_t o_fill
);

  localparam logic [C_CW-1:0] C_H_LAST = C_CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [C_CW-1:0] C_V_LAST = C_CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [C_CW-1:0] C_HS_BEG = C_CW'(H_ACTIVE + H_FP);
  localparam logic [C_CW-1:0] C_HS_FIN = C_CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [C_CW-1:0] C_VS_BEG = C_CW'(V_ACTIVE + V_FP);
  localparam logic [C_CW-1:0] C_VS_FIN = C_CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [C_CW-1:0] r_h;
  logic [C_CW-1:0] r_v;

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == C_H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == C_V_LAST) ? '0 : r_v + C_CW'(1);
    end else begin
      r_h <= r_h + C_CW'(1);
    end
  end

  assign o_hact    = (r_h < C_CW'(H_ACTIVE));
  assign o_vact    = (r_v < C_CW'(V_ACTIVE));
  assign o_visible = o_hact & o_vact;
  assign o_first   = (r_h == '0) && (r_v == '0);
  assign o_hsync_n = !((r_h >= C_HS_BEG) && (r_h < C_HS_FIN));
  assign o_vsync_n = !((r_v >= C_VS_BEG) && (r_v < C_VS_FIN));

`ifdef VGA_COLORBAR_EN
  assign o_fill = '{r: {5{r_h[8]}}, g: {6{r_h[7]}}, b: {5{r_h[6]}}};
`else
  assign o_fill = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_scanout : 640x480 scan-out with sof-aligned RGB565 pixel stream intake.
// Rev 1.0     : fill pixels show colour bars when VGA_COLORBAR_EN is defined.
// ============================================================================
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = C_H_ACTIVE,
  parameter int H_FP     = C_H_FP,
  parameter int H_SYNC   = C_H_SYNC,
  parameter int H_BP     = C_H_BP,
  parameter int V_ACTIVE = C_V_ACTIVE,
  parameter int V_FP     = C_V_FP,
  parameter int V_SYNC   = C_V_SYNC,
  parameter int V_BP     = C_V_BP
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [15:0] pix_data,
  input  logic        pix_sof,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        hsync,
  output logic        vsync,
  output logic        hactive,
  output logic        vactive,
  output logic [4:0]  red,
  output logic [5:0]  green,
  output logic [4:0]  blue,
  output logic        underflow
);

  logic    w_visible;
  logic    w_first;
  logic    w_hsync_n;
  logic    w_vsync_n;
  logic    w_hact;
  logic    w_vact;
  rgb565_t w_fill;
  rgb565_t w_word;
  state_t  r_state;
  rgb565_t r_color;

  vga_scan #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_scan (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .o_visible (w_visible),
    .o_first   (w_first),
    .o_hsync_n (w_hsync_n),
    .o_vsync_n (w_vsync_n),
    .o_hact    (w_hact),
    .o_vact    (w_vact),
    .o_fill    (w_fill)
  );

  assign w_word = rgb565_t'(pix_data);

  // An early sof is held at the head in RUN; DROP discards everything but a sof
  // word, and takes the sof word only at the first pixel.
  always_comb begin
    pix_ready = 1'b0;
    if (reset_n) begin
      if (r_state == RUN)
        pix_ready = w_visible & ~(pix_valid & pix_sof & ~w_first);
      else
        pix_ready = pix_valid & (~pix_sof | w_first);
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      r_state   <= DROP;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      hactive   <= 1'b0;
      vactive   <= 1'b0;
      r_color   <= '0;
      underflow <= 1'b0;
    end else begin
      hsync     <= w_hsync_n;
      vsync     <= w_vsync_n;
      hactive   <= w_hact;
      vactive   <= w_vact;
      underflow <= 1'b0;
      r_color   <= '0;
      if (w_visible) begin
        r_color <= w_fill;
        if (r_state == RUN) begin
          if (!pix_valid) begin
            underflow <= 1'b1;
            if (w_first) r_state <= DROP;
          end else if (pix_sof == w_first) begin
            r_color <= w_word;
          end else begin
            r_state <= DROP;
          end
        end else if (w_first && pix_valid && pix_sof) begin
          r_color <= w_word;
          r_state <= RUN;
        end
      end
    end
  end

  assign red   = r_color.r;
  assign green = r_color.g;
  assign blue  = r_color.b;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`timescale 1ns/1ps
`default_nettype none
// tb_vga_scanout : scoreboard bench for vga_scanout on reduced timing, plus a
// line-timing check of a default 640x480 instance.
module tb_vga_scanout;

  localparam int HA = 160, HFP = 8, HSW = 12, HBP = 20;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VA = 8, VFP = 2, VSW = 2, VBP = 3;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int NPIX  = HA * VA;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pix_data = 16'h0;
  logic        pix_sof = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready, hsync, vsync, hactive, vactive, underflow;
  logic [4:0]  red, blue;
  logic [5:0]  green;
  logic        rdy_d, hs_d, vs_d, ha_d, va_d, uf_d;
  logic [4:0]  r_d, b_d;
  logic [5:0]  g_d;

  always #5 pclk = ~pclk;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .pix_data(pix_data), .pix_sof(pix_sof),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .hsync(hsync), .vsync(vsync),
    .hactive(hactive), .vactive(vactive), .red(red), .green(green), .blue(blue),
    .underflow(underflow)
  );

  vga_scanout dut_d (
    .pclk(pclk), .reset_n(reset_n), .pix_data(16'h0), .pix_sof(1'b0),
    .pix_valid(1'b0), .pix_ready(rdy_d), .hsync(hs_d), .vsync(vs_d),
    .hactive(ha_d), .vactive(va_d), .red(r_d), .green(g_d), .blue(b_d),
    .underflow(uf_d)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        ha;
    logic        va;
    logic [15:0] rgb;
    logic        uf;
  } exp_t;

  typedef struct packed {
    logic        sof;
    logic [15:0] data;
  } word_t;

  exp_t  sbq[$];
  word_t stream[$];
  exp_t  m_e;
  int    ntests = 0, nfail = 0, uf_cnt = 0;
  int    p = 0;
  bit    locked = 1'b0;
  int    valid_pct = 100;
  bit    gap_armed = 1'b0;
  bit    done_d = 1'b0;

  function automatic logic [15:0] fill(input int h);
    bit bars;
    int idx;
    bars = 1'b0;
`ifdef VGA_COLORBAR_EN
    bars = 1'b1;
`endif
    idx = (h / 64) % 8;
    if (!bars) return 16'h0;
    return {{5{idx[2]}}, {6{idx[1]}}, {5{idx[0]}}};
  endfunction

  task automatic expect_eq(input string name, input int got, input int want);
    ntests++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push_frame(input int len, input bit rnd);
    word_t w;
    for (int k = 0; k < len; k++) begin
      w.sof  = (k == 0);
      w.data = rnd ? 16'($urandom) : 16'(k);
      stream.push_back(w);
    end
  endtask

  task automatic push_junk(input int n);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w.sof  = 1'b0;
      w.data = 16'($urandom);
      stream.push_back(w);
    end
  endtask

  // One pixel clock: drive inputs, apply the reference rules, queue expectation.
  task automatic cycle(input bit rst);
    exp_t  e;
    word_t w;
    bit    v, rdy, vis, first;
    int    h, vv, pp;
    v = (stream.size() > 0) && ($urandom_range(0, 99) < valid_pct);
    if (gap_armed && p >= 5*HT + 100 && p < 5*HT + 103) v = 1'b0;
    w.sof  = 1'($urandom);
    w.data = 16'($urandom);
    if (v) w = stream[0];
    reset_n   = !rst;
    pix_valid = v;
    pix_sof   = w.sof;
    pix_data  = w.data;
    @(negedge pclk);
    pp = p;
    if (rst) begin
      rdy = 1'b0;
      e = '{hs: 1'b1, vs: 1'b1, ha: 1'b0, va: 1'b0, rgb: 16'h0, uf: 1'b0};
      p = 0;
      locked = 1'b0;
    end else begin
      h = p % HT;
      vv = p / HT;
      vis = (h < HA) && (vv < VA);
      first = (p == 0);
      e.hs = !(h >= HA + HFP && h < HA + HFP + HSW);
      e.vs = !(vv >= VA + VFP && vv < VA + VFP + VSW);
      e.ha = (h < HA);
      e.va = (vv < VA);
      e.uf = 1'b0;
      e.rgb = vis ? fill(h) : 16'h0;
      if (!locked) begin
        rdy = v && (!w.sof || first);
        if (first && v && w.sof) begin
          e.rgb = w.data;
          locked = 1'b1;
        end
      end else if (!vis) begin
        rdy = 1'b0;
      end else begin
        rdy = !(v && w.sof && !first);
        if (!v) begin
          e.uf = 1'b1;
          if (first) locked = 1'b0;
        end else if (first) begin
          if (w.sof) e.rgb = w.data;
          else locked = 1'b0;
        end else if (w.sof) begin
          locked = 1'b0;
        end else begin
          e.rgb = w.data;
        end
      end
      p = (p + 1) % FRAME;
    end
    ntests++;
    if (pix_ready !== rdy) begin
      nfail++;
      $display("FAIL pix_ready at pixel %0d: got %b want %b", pp, pix_ready, rdy);
    end
    if (v && rdy) w = stream.pop_front();
    sbq.push_back(e);
    @(posedge pclk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  always @(posedge pclk) begin
    #2;
    if (sbq.size() > 0) begin
      m_e = sbq.pop_front();
      ntests++;
      if (underflow === 1'b1) uf_cnt++;
      if ({hsync, vsync, hactive, vactive, red, green, blue, underflow} !== m_e) begin
        nfail++;
        $display("FAIL scan_out: got hs=%b vs=%b ha=%b va=%b rgb=%h uf=%b want hs=%b vs=%b ha=%b va=%b rgb=%h uf=%b",
                 hsync, vsync, hactive, vactive, {red, green, blue}, underflow,
                 m_e.hs, m_e.vs, m_e.ha, m_e.va, m_e.rgb, m_e.uf);
      end
    end
  end

  // Full-size timing: one 800-clock line with 96 low hsync clocks and 640 active.
  initial begin : chk_default
    int n, low, act, vhi;
    logic prev;
    wait (reset_n === 1'b1);
    n = 0;
    do begin
      @(posedge pclk);
      #2;
      n++;
    end while (hs_d !== 1'b0 && n < 2000);
    expect_eq("hsync_first_fall_found", int'(n < 2000), 1);
    low = 1;
    act = (ha_d === 1'b1) ? 1 : 0;
    vhi = 0;
    prev = hs_d;
    for (int i = 1; i <= 800; i++) begin
      @(posedge pclk);
      #2;
      if (i < 800) begin
        prev = hs_d;
        if (hs_d === 1'b0) low++;
        if (ha_d === 1'b1) act++;
      end
      if (vs_d === 1'b1 && va_d === 1'b1) vhi++;
    end
    expect_eq("hsync_period_fall", int'(hs_d === 1'b0 && prev === 1'b1), 1);
    expect_eq("hsync_low_clocks", low, 96);
    expect_eq("hactive_clocks", act, 640);
    expect_eq("vsync_high_line0", vhi, 800);
    done_d = 1'b1;
  end

  initial begin
    push_frame(NPIX, 1'b0);
    push_frame(NPIX, 1'b0);
    repeat (3) cycle(1'b1);
    uf_cnt = 0;
    run(2 * FRAME);
    expect_eq("uf_count_counting_stream", uf_cnt, 0);

    stream.delete();
    push_frame(NPIX, 1'b0);
    gap_armed = 1'b1;
    uf_cnt = 0;
    run(FRAME);
    gap_armed = 1'b0;
    expect_eq("uf_count_valid_gap", uf_cnt, 3);

    stream.delete();
    push_junk(5);
    push_frame(NPIX, 1'b1);
    push_frame(NPIX, 1'b1);
    uf_cnt = 0;
    run(3 * FRAME);
    expect_eq("uf_count_junk_realign", uf_cnt, 0);

    stream.delete();
    push_frame(5 * HA + 100, 1'b1);
    push_frame(NPIX, 1'b1);
    push_frame(NPIX, 1'b1);
    uf_cnt = 0;
    run(3 * FRAME);
    expect_eq("uf_count_early_sof", uf_cnt, 0);

    stream.delete();
    push_frame(NPIX, 1'b1);
    push_frame(NPIX, 1'b1);
    run(200 * 0 + 5 * HT + 100);
    cycle(1'b1);
    cycle(1'b1);
    run(2 * FRAME);

    valid_pct = 90;
    stream.delete();
    for (int f = 0; f < 5; f++) begin
      if ($urandom_range(0, 2) == 0) push_junk($urandom_range(1, 6));
      push_frame(($urandom_range(0, 1) == 0) ? NPIX : NPIX - $urandom_range(1, 40), 1'b1);
    end
    run(4 * FRAME);

    @(posedge pclk);
    #3;
    expect_eq("scoreboard_drained", sbq.size(), 0);
    expect_eq("default_timing_done", int'(done_d), 1);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
